// File: rtl/alu_ctrl_decode_pkg.sv
// Shared definitions for the ALU control decode stage: opcodes, funct codes,
// occupancy state encodings and the decoded-entry payload.
package alu_ctrl_decode_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned FN_W    = 2;
  localparam int unsigned IMM_W   = 16;

  localparam logic [OP_W-1:0] OP_ADDI  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SUBI  = 5'b01001;
  localparam logic [OP_W-1:0] OP_XORI  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ANDNI = 5'b01011;
  localparam logic [OP_W-1:0] OP_SLBI  = 5'b10010;
  localparam logic [OP_W-1:0] OP_ROLI  = 5'b10100;
  localparam logic [OP_W-1:0] OP_SLLI  = 5'b10101;
  localparam logic [OP_W-1:0] OP_RORI  = 5'b10110;
  localparam logic [OP_W-1:0] OP_SRLI  = 5'b10111;
  localparam logic [OP_W-1:0] OP_LBI   = 5'b11000;
  localparam logic [OP_W-1:0] OP_BTR   = 5'b11001;
  localparam logic [OP_W-1:0] OP_SHIFT = 5'b11010;
  localparam logic [OP_W-1:0] OP_ARITH = 5'b11011;
  localparam logic [OP_W-1:0] OP_SEQ   = 5'b11100;
  localparam logic [OP_W-1:0] OP_SLT   = 5'b11101;
  localparam logic [OP_W-1:0] OP_SLE   = 5'b11110;
  localparam logic [OP_W-1:0] OP_SCO   = 5'b11111;

  localparam logic [FN_W-1:0] FN_ADD  = 2'b00;
  localparam logic [FN_W-1:0] FN_SUB  = 2'b01;
  localparam logic [FN_W-1:0] FN_XOR  = 2'b10;
  localparam logic [FN_W-1:0] FN_ANDN = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             inv_a;
    logic             inv_b;
    logic             cin;
    logic [FN_W-1:0]  lower_two;
    logic [IMM_W-1:0] imm16;
    logic             use_imm;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode_if.sv
// Instruction-in / ALU-control-out channel of the decode stage.
// The trap signal exists only when ALU_DEC_TRAP_EN is defined.
interface alu_ctrl_decode_if #(
  parameter int unsigned IW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] instr;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    op;
  logic          inv_a;
  logic          inv_b;
  logic          cin;
  logic [1:0]    lower_two;
  logic [15:0]   imm16;
  logic          use_imm;
  logic          illegal;
`ifdef ALU_DEC_TRAP_EN
  logic          trap;
`endif

  // Environment side: fetch/issue drives instructions, execute consumes controls.
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, op, inv_a, inv_b, cin, lower_two, imm16,
           use_imm, illegal
`ifdef ALU_DEC_TRAP_EN
    , input trap
`endif
  );

  // Decode stage side.
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, op, inv_a, inv_b, cin, lower_two, imm16,
           use_imm, illegal
`ifdef ALU_DEC_TRAP_EN
    , output trap
`endif
  );
endinterface

// File: rtl/alu_ctrl_comb.sv
// Purely combinational WISC-SP13 instruction to ALU control decode.
module alu_ctrl_comb
  import alu_ctrl_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl_c
);

  logic [OP_W-1:0] op;
  logic [IMM_W-1:0] sext5, zext5, sext8, zext8, zext4;
  logic unused_instr_bits;

  assign op    = instr[15:11];
  assign sext5 = {{11{instr[4]}}, instr[4:0]};
  assign zext5 = {11'b0, instr[4:0]};
  assign sext8 = {{8{instr[7]}}, instr[7:0]};
  assign zext8 = {8'b0, instr[7:0]};
  assign zext4 = {12'b0, instr[3:0]};
  // Register specifier bits are not needed for ALU control.
  assign unused_instr_bits = ^instr[10:8];

  always_comb begin
    ctrl_c    = '0;
    ctrl_c.op = op;
    unique case (op)
      OP_ADDI:  begin ctrl_c.imm16 = sext5; ctrl_c.use_imm = 1'b1; end
      OP_SUBI:  begin
        ctrl_c.imm16   = sext5;
        ctrl_c.inv_a   = 1'b1;
        ctrl_c.cin     = 1'b1;
        ctrl_c.use_imm = 1'b1;
      end
      OP_XORI:  begin ctrl_c.imm16 = zext5; ctrl_c.use_imm = 1'b1; end
      OP_ANDNI: begin
        ctrl_c.imm16   = zext5;
        ctrl_c.inv_b   = 1'b1;
        ctrl_c.use_imm = 1'b1;
      end
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        ctrl_c.imm16   = zext4;
        ctrl_c.use_imm = 1'b1;
      end
      OP_ARITH: begin
        ctrl_c.lower_two = instr[1:0];
        unique case (instr[1:0])
          FN_SUB:  begin ctrl_c.inv_a = 1'b1; ctrl_c.cin = 1'b1; end
          FN_ANDN: ctrl_c.inv_b = 1'b1;
          default: ;
        endcase
      end
      OP_SHIFT: ctrl_c.lower_two = instr[1:0];
      OP_SEQ, OP_SLT, OP_SLE: begin ctrl_c.inv_b = 1'b1; ctrl_c.cin = 1'b1; end
      OP_SCO, OP_BTR: ;
      OP_LBI:   begin ctrl_c.imm16 = sext8; ctrl_c.use_imm = 1'b1; end
      OP_SLBI:  begin ctrl_c.imm16 = zext8; ctrl_c.use_imm = 1'b1; end
      default:  ctrl_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Pipelined ALU control decode stage with a 2-entry skid buffer.
// Define ALU_DEC_TRAP_EN to add a sticky trap on illegal-opcode retirement.
module alu_ctrl_decode
  import alu_ctrl_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_ctrl_decode_if.slave   bus
);

  if (DEPTH != 2 || IW != INSTR_W) begin : g_bad_cfg
    $error("alu_ctrl_decode: only DEPTH=2 and IW=16 are supported");
  end

  occ_state_e state_q, state_d;
  ctrl_t      head_q, head_d;
  ctrl_t      tail_q, tail_d;
  ctrl_t      dec_c;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;
`ifdef ALU_DEC_TRAP_EN
  logic       trap_q, trap_d;
`endif

  // Decode at the input so buffered entries hold ready-to-use control fields.
  alu_ctrl_comb u_comb (
    .instr  (bus.instr),
    .ctrl_c (dec_c)
  );

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: if (push) begin
        head_d  = dec_c;
        state_d = ONE;
      end
      ONE: begin
        if (push && pop) begin
          head_d = dec_c;
        end else if (push) begin
          tail_d  = dec_c;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        head_d  = tail_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;

    out_valid_d = (state_d != EMPTY);
`ifdef ALU_DEC_TRAP_EN
    trap_d = trap_q | (pop & head_q.illegal);
    if (flush) trap_d = 1'b0;
    in_ready_d = (state_d != FULL) && !trap_d;
`else
    in_ready_d = (state_d != FULL);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef ALU_DEC_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end
  assign bus.trap = trap_q;
`endif

  // Head entry is a flop, so every control output comes straight from a register.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op        = head_q.op;
  assign bus.inv_a     = head_q.inv_a;
  assign bus.inv_b     = head_q.inv_b;
  assign bus.cin       = head_q.cin;
  assign bus.lower_two = head_q.lower_two;
  assign bus.imm16     = head_q.imm16;
  assign bus.use_imm   = head_q.use_imm;
  assign bus.illegal   = head_q.illegal;

endmodule
